// File: rtl/wb_sram_responder.sv
// Wishbone classic responder mapping a 2^ADDR_W x 32 word window onto a
// dual-port SRAM macro. Port 0 carries writes only and port 1 carries reads only.
// Read data and the single-cycle ack are registered.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i    Wishbone request qualifiers
//   wbs_adr_i, wbs_dat_i          byte address, write data
//   wbs_ack_o, wbs_dat_o          registered acknowledge and read data
//   o_csb0/o_web0/o_wmask0/o_waddr0/o_din0   SRAM write port (active-low strobes)
//   o_csb1/o_addr1, i_dout1       SRAM read port
module wb_sram_responder #(
    parameter int unsigned ADDR_W    = 9,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK = 32'hFFFF_F800
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              o_csb0,
    output logic              o_web0,
    output logic [3:0]        o_wmask0,
    output logic [ADDR_W-1:0] o_waddr0,
    output logic [31:0]       o_din0,
    output logic              o_csb1,
    output logic [ADDR_W-1:0] o_addr1,
    input  logic [31:0]       i_dout1
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic              ack_q,    ack_d;
    logic [DATA_W-1:0] dat_q,    dat_d;
    logic              csb0_q,   csb0_d;
    logic              web0_q,   web0_d;
    logic [SEL_W-1:0]  wmask0_q, wmask0_d;
    logic [ADDR_W-1:0] waddr0_q, waddr0_d;
    logic [DATA_W-1:0] din0_q,   din0_d;
    logic              csb1_q,   csb1_d;
    logic [ADDR_W-1:0] addr1_q,  addr1_d;

    logic              valid_c;
    logic              hit_c;
    logic [ADDR_W-1:0] word_addr_c;

    assign valid_c     = wbs_cyc_i & wbs_stb_i;
    assign hit_c       = (wbs_adr_i & BASE_MASK) == (BASE_ADDR & BASE_MASK);
    assign word_addr_c = wbs_adr_i[ADDR_W+1:2];

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;
        csb0_d   = csb0_q;
        web0_d   = web0_q;
        wmask0_d = wmask0_q;
        waddr0_d = waddr0_q;
        din0_d   = din0_q;
        csb1_d   = csb1_q;
        addr1_d  = addr1_q;

        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    if (hit_c) begin
                        if (wbs_we_i) begin
                            csb0_d   = 1'b0;
                            web0_d   = 1'b0;
                            waddr0_d = word_addr_c;
                            din0_d   = wbs_dat_i;
                            wmask0_d = wbs_sel_i;
                        end else begin
                            csb1_d  = 1'b0;
                            addr1_d = word_addr_c;
                        end
                        state_d = ISSUE;
                    end else begin
                        dat_d   = '0;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            ISSUE: begin
                // Strobes are live for exactly this cycle; web0_q still tells write from read.
                csb0_d = 1'b1;
                web0_d = 1'b1;
                csb1_d = 1'b1;
                if (!web0_q) begin
                    ack_d   = wbs_cyc_i;
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Read data is captured even when the master has abandoned the cycle.
                dat_d   = i_dout1;
                ack_d   = wbs_cyc_i;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            waddr0_q <= '0;
            din0_q   <= '0;
            csb1_q   <= 1'b1;
            addr1_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            csb0_q   <= csb0_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            waddr0_q <= waddr0_d;
            din0_q   <= din0_d;
            csb1_q   <= csb1_d;
            addr1_q  <= addr1_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign o_csb0    = csb0_q;
    assign o_web0    = web0_q;
    assign o_wmask0  = wmask0_q;
    assign o_waddr0  = waddr0_q;
    assign o_din0    = din0_q;
    assign o_csb1    = csb1_q;
    assign o_addr1   = addr1_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench for wb_sram_responder with a behavioural SRAM macro and a
// scoreboard of expected read data.
module tb_wb_sram_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        o_csb0, o_web0, o_csb1;
    logic [3:0]  o_wmask0;
    logic [8:0]  o_waddr0, o_addr1;
    logic [31:0] o_din0;
    logic [31:0] i_dout1;

    int vectors = 0;
    int fails = 0;

    logic [31:0] sram_mem [512];
    logic [31:0] ref_mem  [512];
    logic [31:0] exp_q [$];
    logic [31:0] last_dat = 32'h0;

    always #5 clk_i = ~clk_i;

    wb_sram_responder dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .o_csb0    (o_csb0),
        .o_web0    (o_web0),
        .o_wmask0  (o_wmask0),
        .o_waddr0  (o_waddr0),
        .o_din0    (o_din0),
        .o_csb1    (o_csb1),
        .o_addr1   (o_addr1),
        .i_dout1   (i_dout1)
    );

    // Behavioural dual-port SRAM: masked write on port 0, one-cycle read on port 1.
    always @(posedge clk_i) begin
        if (!o_csb0 && !o_web0) begin
            for (int b = 0; b < 4; b++)
                if (o_wmask0[b]) sram_mem[o_waddr0][8*b +: 8] <= o_din0[8*b +: 8];
        end
        if (!o_csb1) i_dout1 <= sram_mem[o_addr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_hit(input logic [31:0] adr);
        return (adr & 32'hFFFF_F800) == 32'h3000_0000;
    endfunction

    // One Wishbone transaction observed for 8 cycles. exp_lat < 0 means no ack expected.
    // drop_at > 0 drops cyc/stb at the start of that cycle index (request cycle = 0).
    task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input int exp_lat, input int drop_at);
        logic        hit;
        logic [8:0]  idx;
        logic [31:0] exp_d, wa, ra, wm, wd;
        int ack_cyc, ack_n, csb0_n, csb1_n, csb0_at, csb1_at;
        hit = is_hit(adr);
        idx = adr[10:2];
        ack_cyc = -1; ack_n = 0; csb0_n = 0; csb1_n = 0; csb0_at = -1; csb1_at = -1;
        wa = '0; ra = '0; wm = '0; wd = '0;
        if (hit && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
        end else begin
            exp_d = hit ? ref_mem[idx] : 32'h0;
            exp_q.push_back(exp_d);
        end
        @(posedge clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (wbs_ack_o) begin
                ack_n++;
                if (ack_cyc < 0) begin
                    ack_cyc = k;
                    if (!(hit && we)) begin
                        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'h1, 32'h0);
                        else begin
                            exp_d = exp_q.pop_front();
                            chk({tag, "_rdata"}, wbs_dat_o, exp_d);
                            last_dat = exp_d;
                        end
                    end
                end
            end
            if (!o_csb0) begin
                csb0_n++; csb0_at = k;
                wa = 32'(o_waddr0); wm = 32'(o_wmask0); wd = o_din0;
                chk({tag, "_web0"}, 32'(o_web0), 32'h0);
            end
            if (!o_csb1) begin
                csb1_n++; csb1_at = k; ra = 32'(o_addr1);
            end
            @(posedge clk_i); #1;
            if (k + 1 == drop_at || k == ack_cyc) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(exp_lat));
        chk({tag, "_ack_count"}, 32'(ack_n), (exp_lat >= 0) ? 32'h1 : 32'h0);
        chk({tag, "_csb0_count"}, 32'(csb0_n), (hit && we) ? 32'h1 : 32'h0);
        chk({tag, "_csb1_count"}, 32'(csb1_n), (hit && !we) ? 32'h1 : 32'h0);
        if (hit && we) begin
            chk({tag, "_csb0_cycle"}, 32'(csb0_at), 32'h1);
            chk({tag, "_waddr0"}, wa, 32'(idx));
            chk({tag, "_wmask0"}, wm, 32'(sel));
            chk({tag, "_din0"}, wd, dat);
            chk({tag, "_dat_held"}, wbs_dat_o, last_dat);
        end
        if (hit && !we) begin
            chk({tag, "_csb1_cycle"}, 32'(csb1_at), 32'h1);
            chk({tag, "_addr1"}, ra, 32'(idx));
        end
        if (exp_lat < 0 && !(hit && we)) begin
            if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'h1, 32'h0);
            else begin
                exp_d = exp_q.pop_front();
                chk({tag, "_abort_rdata"}, wbs_dat_o, exp_d);
                last_dat = exp_d;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i]  = 32'hC0DE_0000 | 32'(i);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_csb0", 32'(o_csb0), 32'h1);
        chk("rst_web0", 32'(o_web0), 32'h1);
        chk("rst_csb1", 32'(o_csb1), 32'h1);
        chk("rst_wmask0", 32'(o_wmask0), 32'h0);
        chk("rst_waddr0", 32'(o_waddr0), 32'h0);
        chk("rst_din0", o_din0, 32'h0);
        chk("rst_addr1", 32'(o_addr1), 32'h0);
        @(posedge clk_i); #2 rst_ni = 1'b1;

        txn("wr_full",  1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 2, 0);
        txn("rd_full",  1'b0, 32'h3000_0010, 32'h0,         4'h0, 3, 0);
        txn("wr_byte",  1'b1, 32'h3000_0010, 32'h0000_7700, 4'h2, 2, 0);
        txn("rd_byte",  1'b0, 32'h3000_0010, 32'h0,         4'h0, 3, 0);
        txn("miss_rd",  1'b0, 32'h3000_0800, 32'h0,         4'h0, 1, 0);
        txn("rd_low",   1'b0, 32'h3000_0004, 32'h0,         4'h0, 3, 0);
        txn("miss_wr",  1'b1, 32'h2000_0000, 32'h1111_2222, 4'hF, 1, 0);
        txn("wr_top",   1'b1, 32'h3000_07FF, 32'h1357_9BDF, 4'hF, 2, 0);
        txn("rd_abort", 1'b0, 32'h3000_07FC, 32'h0,         4'h0, -1, 2);
        txn("rd_after", 1'b0, 32'h3000_0010, 32'h0,         4'h0, 3, 0);
        txn("wr_sel0",  1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0, 2, 0);
        txn("rd_sel0",  1'b0, 32'h3000_0010, 32'h0,         4'h0, 3, 0);

        // stb without cyc must be ignored
        @(posedge clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'hDEAD_BEEF; wbs_sel_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("nocyc_quiet", {29'h0, wbs_ack_o, o_csb0, o_csb1}, 32'h3);
        end
        @(posedge clk_i); #1 wbs_stb_i = 1'b0;

        // Reset while a write is in ISSUE
        @(posedge clk_i); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'h0BAD_F00D; wbs_sel_i = 4'hF;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rstmid_issue_csb0", 32'(o_csb0), 32'h0);
        #2 rst_ni = 1'b0;
        #1;
        chk("rstmid_csb0", 32'(o_csb0), 32'h1);
        chk("rstmid_web0", 32'(o_web0), 32'h1);
        chk("rstmid_ack", 32'(wbs_ack_o), 32'h0);
        chk("rstmid_dat", wbs_dat_o, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        last_dat = 32'h0;
        @(posedge clk_i); #2 rst_ni = 1'b1;

        txn("rd_fresh",   1'b0, 32'h3000_0100, 32'h0, 4'h0, 3, 0);
        txn("rd_dropped", 1'b0, 32'h3000_0020, 32'h0, 4'h0, 3, 0);

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
